// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory request/response bus.
// master: the fetch unit. It drives imem_req and imem_addr, and it samples
//         imem_gnt, imem_rvalid and imem_rdata.
// slave : the instruction memory. It drives imem_gnt, imem_rvalid and imem_rdata.
// Only one request is in flight at a time. Each grant is followed by exactly
// one rvalid, at least one cycle later.
interface instruction_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage. It sits between the program counter and the IF/ID
// boundary.
// It fetches one instruction for each pc_current, with one memory request in
// flight at a time. The response lands in the IF/ID output register, or in a
// 1-entry skid register when decode is stalled.
// Ports:
//   clock, reset      rising-edge clock; asynchronous active-high reset
//   pc_current        address to fetch, from the program counter
//   pc_enable         PC advances at the next edge
//                     (set on an accepted request or on a flush)
//   flush             redirect this cycle; kills any wrong-path fetch
//   stall_id          decode cannot accept; IF/ID holds its contents
//   imem              instruction memory bus (master side)
//   if_id_valid/pc/pc_plus4/instr
//                     IF/ID register; instr is NOP_INSTR when not valid
//   fetch_misaligned  request blocked because pc_current is not word aligned
//
// state | meaning
// ------+------------------------------------------------------------
// REQ   | presenting a request for pc_current (when allowed)
// WAIT  | request granted, waiting for its response
// DROP  | flushed while waiting; the pending response will be discarded
module instruction_fetch_unit #(
    parameter logic [31:0] NOP_INSTR   = 32'h00000013,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [31:0]                     pc_current,
    output logic                            pc_enable,
    input  logic                            flush,
    input  logic                            stall_id,
    instruction_fetch_unit_if.master        imem,
    output logic                            if_id_valid,
    output logic [31:0]                     if_id_pc,
    output logic [31:0]                     if_id_pc_plus4,
    output logic [31:0]                     if_id_instr,
    output logic                            fetch_misaligned
);

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] req_pc;
    logic        skid_valid;
    logic [31:0] skid_pc;
    logic [31:0] skid_instr;

    logic        misaligned;
    logic        req_fire;
    logic        deliver;
    logic        out_free;

    assign misaligned = CHECK_ALIGN && (pc_current[1:0] != 2'b00);

    // A full skid blocks new requests. This is what makes skid overflow
    // impossible: at most one response can be outstanding while the skid
    // holds data.
    always_comb begin
        imem.imem_req = 1'b0;
        if (!reset && (state == ST_REQ)) begin
            imem.imem_req = !flush && !skid_valid && !misaligned;
        end
    end

    assign imem.imem_addr   = pc_current;
    assign req_fire         = imem.imem_req && imem.imem_gnt;
    assign pc_enable        = !reset && (req_fire || flush);
    assign fetch_misaligned = !reset && (state == ST_REQ) && misaligned;

    // A response counts only in WAIT and only without a flush. If it
    // arrives in REQ, it is left over from before a reset and is dropped.
    assign deliver  = (state == ST_WAIT) && imem.imem_rvalid && !flush;
    assign out_free = !if_id_valid || !stall_id;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_REQ;
            req_pc         <= 32'h0;
            skid_valid     <= 1'b0;
            skid_pc        <= 32'h0;
            skid_instr     <= NOP_INSTR;
            if_id_valid    <= 1'b0;
            if_id_pc       <= 32'h0;
            if_id_pc_plus4 <= 32'h4;
            if_id_instr    <= NOP_INSTR;
        end else begin
            case (state)
                ST_REQ: begin
                    if (req_fire) begin
                        state  <= ST_WAIT;
                        req_pc <= pc_current;
                    end
                end
                ST_WAIT: begin
                    if (flush) begin
                        state <= ST_DROP;
                    end else if (imem.imem_rvalid) begin
                        state <= ST_REQ;
                    end
                end
                ST_DROP: begin
                    if (!flush && imem.imem_rvalid) begin
                        state <= ST_REQ;
                    end
                end
                default: state <= ST_REQ;
            endcase

            if (flush) begin
                if_id_valid <= 1'b0;
                if_id_instr <= NOP_INSTR;
                skid_valid  <= 1'b0;
            end else if (out_free) begin
                // The skid and a new delivery never occur together: no request
                // is issued while the skid holds data.
                if (skid_valid) begin
                    if_id_valid    <= 1'b1;
                    if_id_pc       <= skid_pc;
                    if_id_pc_plus4 <= skid_pc + 32'd4;
                    if_id_instr    <= skid_instr;
                    skid_valid     <= 1'b0;
                end else if (deliver) begin
                    if_id_valid    <= 1'b1;
                    if_id_pc       <= req_pc;
                    if_id_pc_plus4 <= req_pc + 32'd4;
                    if_id_instr    <= imem.imem_rdata;
                end else begin
                    if_id_valid <= 1'b0;
                    if_id_instr <= NOP_INSTR;
                end
            end else if (deliver) begin
                skid_valid <= 1'b1;
                skid_pc    <= req_pc;
                skid_instr <= imem.imem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit.
// The bench models the program counter and a memory that returns
// addr ^ A5A5A5A5 after a programmable latency. Expected IF/ID contents are
// hand-computed and queued. A negedge monitor pops and compares an entry each
// time decode consumes IF/ID (valid, no stall, no flush).
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
    } exp_t;

    logic        clock;
    logic        reset;
    logic [31:0] pc;
    logic        pc_enable;
    logic        flush;
    logic        stall_id;
    logic        if_id_valid;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus4;
    logic [31:0] if_id_instr;
    logic        fetch_misaligned;

    instruction_fetch_unit_if bus ();

    instruction_fetch_unit #(
        .NOP_INSTR  (NOP),
        .CHECK_ALIGN(1'b1)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .pc_current      (pc),
        .pc_enable       (pc_enable),
        .flush           (flush),
        .stall_id        (stall_id),
        .imem            (bus.master),
        .if_id_valid     (if_id_valid),
        .if_id_pc        (if_id_pc),
        .if_id_pc_plus4  (if_id_pc_plus4),
        .if_id_instr     (if_id_instr),
        .fetch_misaligned(fetch_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          n_cmp = 0;
    int          n_err = 0;
    exp_t        exp_q[$];

    logic [31:0] pc_target;
    int          mem_lat;
    logic        pend_valid;
    logic [31:0] pend_addr;
    int          pend_cnt;

    // Snapshot of the most recent cycle, taken at its negedge.
    logic        s_req, s_pcen, s_mis, s_fire, s_valid;
    logic [31:0] s_addr, s_pc, s_pc4, s_instr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", name, act, want, $time);
        end
    endtask

    task automatic push(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = a ^ 32'hA5A5A5A5;
        e.pc4   = a + 32'd4;
        exp_q.push_back(e);
    endtask

    // One clock cycle. At the negedge the bench samples the DUT, accepts any
    // granted request and computes the next PC. At 1 time unit after the
    // posedge it applies the new PC and the memory response.
    task automatic step();
        logic [31:0] nxt_pc;
        @(negedge clock);
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_pcen  = pc_enable;
        s_mis   = fetch_misaligned;
        s_fire  = bus.imem_req & bus.imem_gnt;
        s_valid = if_id_valid;
        s_pc    = if_id_pc;
        s_pc4   = if_id_pc_plus4;
        s_instr = if_id_instr;
        if (reset) begin
            pend_valid = 1'b0;
        end else if (s_fire) begin
            pend_valid = 1'b1;
            pend_addr  = bus.imem_addr;
            pend_cnt   = mem_lat;
        end
        nxt_pc = pc;
        if (pc_enable) nxt_pc = flush ? pc_target : pc + 32'd4;
        @(posedge clock);
        #1;
        pc = nxt_pc;
        bus.imem_rvalid = 1'b0;
        if (pend_valid) begin
            if (pend_cnt <= 1) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = pend_addr ^ 32'hA5A5A5A5;
                pend_valid      = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
    endtask

    task automatic do_flush(input logic [31:0] tgt);
        flush     = 1'b1;
        pc_target = tgt;
        step();
        flush     = 1'b0;
    endtask

    task automatic run_grants(input int k);
        int got;
        got = 0;
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 40 && got < k; i++) begin
            step();
            if (s_fire) got++;
        end
        bus.imem_gnt = 1'b0;
        chk("grant_count", 32'(got), 32'(k));
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (!if_id_valid) chk("instr_nop_when_invalid", if_id_instr, NOP);
            if (!reset && if_id_valid && !stall_id && !flush) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: got pc %h instr %h want nothing", if_id_pc, if_id_instr);
                end else begin
                    e = exp_q.pop_front();
                    chk("if_id_pc", if_id_pc, e.pc);
                    chk("if_id_pc_plus4", if_id_pc_plus4, e.pc4);
                    chk("if_id_instr", if_id_instr, e.instr);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset           = 1'b1;
        pc              = 32'h0;
        pc_target       = 32'h0;
        flush           = 1'b0;
        stall_id        = 1'b0;
        mem_lat         = 1;
        pend_valid      = 1'b0;
        pend_addr       = 32'h0;
        pend_cnt        = 0;
        bus.imem_gnt    = 1'b1;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        // Reset state. The grant is held high to show that no request leaks.
        step();
        step();
        chk("rst_req", 32'(s_req), 32'd0);
        chk("rst_pcen", 32'(s_pcen), 32'd0);
        chk("rst_valid", 32'(s_valid), 32'd0);
        chk("rst_pc", s_pc, 32'h0);
        chk("rst_pc4", s_pc4, 32'h4);
        chk("rst_instr", s_instr, NOP);
        reset        = 1'b0;
        bus.imem_gnt = 1'b0;

        // 1: back-to-back fetch of 0, 4, 8.
        push(32'h0); push(32'h4); push(32'h8);
        run_grants(3);
        drain();

        // 2: grant withheld for 3 cycles at 0x10.
        do_flush(32'h10);
        push(32'h10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t2_req_held", 32'(s_req), 32'd1);
            chk("t2_addr_held", s_addr, 32'h10);
            chk("t2_pcen_low", 32'(s_pcen), 32'd0);
        end
        run_grants(1);
        chk("t2_granted_addr", s_addr, 32'h10);
        drain();

        // 3: stall for 4 cycles while 0x20 and 0x24 are fetched.
        do_flush(32'h20);
        push(32'h20); push(32'h24);
        bus.imem_gnt = 1'b1;
        step();
        step();
        stall_id = 1'b1;
        step();
        chk("t3_req_24", s_addr, 32'h24);
        chk("t3_fire_24", 32'(s_fire), 32'd1);
        bus.imem_gnt = 1'b0;
        step();
        chk("t3_hold_pc", s_pc, 32'h20);
        step();
        chk("t3_skid_blocks_req", 32'(s_req), 32'd0);
        chk("t3_hold_valid", 32'(s_valid), 32'd1);
        step();
        chk("t3_skid_blocks_req2", 32'(s_req), 32'd0);
        stall_id = 1'b0;
        step();
        chk("t3_still_20", s_pc, 32'h20);
        chk("t3_req_until_drain", 32'(s_req), 32'd0);
        step();
        chk("t3_skid_out_pc", s_pc, 32'h24);
        chk("t3_skid_out_valid", 32'(s_valid), 32'd1);
        chk("t3_next_req_28", s_addr, 32'h28);
        chk("t3_next_req_on", 32'(s_req), 32'd1);
        drain();

        // 4: flush while waiting on 0x30; redirect to 0x1000.
        mem_lat = 2;
        do_flush(32'h30);
        run_grants(1);
        do_flush(32'h1000);
        chk("t4_flush_pcen", 32'(s_pcen), 32'd1);
        chk("t4_no_req_in_wait", 32'(s_req), 32'd0);
        step();
        chk("t4_drop_no_req", 32'(s_req), 32'd0);
        chk("t4_valid_cleared", 32'(s_valid), 32'd0);
        chk("t4_instr_nop", s_instr, NOP);
        mem_lat = 1;
        push(32'h1000);
        run_grants(1);
        chk("t4_fetch_1000", s_addr, 32'h1000);
        drain();

        // 5: misaligned target blocks fetch until redirected.
        do_flush(32'h102);
        bus.imem_gnt = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t5_misaligned", 32'(s_mis), 32'd1);
            chk("t5_no_req", 32'(s_req), 32'd0);
            chk("t5_pcen_low", 32'(s_pcen), 32'd0);
        end
        do_flush(32'h200);
        push(32'h200);
        run_grants(1);
        chk("t5_fetch_200", s_addr, 32'h200);
        chk("t5_mis_clear", 32'(s_mis), 32'd0);
        drain();

        // 6: wrap at the top of memory, then reset in the middle of a WAIT.
        do_flush(32'hFFFFFFFC);
        run_grants(1);
        chk("t6_fetch_top", s_addr, 32'hFFFFFFFC);
        step();
        stall_id     = 1'b1;
        bus.imem_gnt = 1'b1;
        step();
        bus.imem_gnt = 1'b0;
        chk("t6_pc_top", s_pc, 32'hFFFFFFFC);
        chk("t6_pc4_wrap", s_pc4, 32'h0);
        chk("t6_instr", s_instr, 32'h5A5A5A59);
        chk("t6_next_fetch_0", s_addr, 32'h0);
        chk("t6_next_fire", 32'(s_fire), 32'd1);
        reset      = 1'b1;
        pend_valid = 1'b0;
        #1;
        chk("t6_rst_valid", 32'(if_id_valid), 32'd0);
        chk("t6_rst_pc", if_id_pc, 32'h0);
        chk("t6_rst_pc4", if_id_pc_plus4, 32'h4);
        chk("t6_rst_instr", if_id_instr, NOP);
        chk("t6_rst_req", 32'(bus.imem_req), 32'd0);
        chk("t6_rst_pcen", 32'(pc_enable), 32'd0);
        pc = 32'h0;
        step();
        reset           = 1'b0;
        stall_id        = 1'b0;
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = 32'hDEADBEEF;
        step();
        step();
        chk("t6_stale_ignored", 32'(s_valid), 32'd0);
        push(32'h0);
        run_grants(1);
        drain();
        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
